// File: rtl/interrupt_arbiter_if.sv
// Bus-side signal bundle for interrupt_arbiter: CPU IACK decode, local irq/iack,
// VME backplane IPL/IACK and the prioritized IPL/autovector back to the CPU.
interface interrupt_arbiter_if #(
  parameter int unsigned NUM_SOURCES = 4
);
  logic                   cpu_as;
  logic [2:0]             cpu_fc;
  logic                   address_16;
  logic [2:0]             cpu_ack_level;
  logic [2:0]             cpu_ipl;
  logic                   cpu_avec;
  logic [NUM_SOURCES-1:0] irq;
  logic [NUM_SOURCES-1:0] iack;
  logic                   dev_dtack;
  logic [2:0]             vme_ipl;
  logic                   vme_iack;

  // master is the card environment (CPU bus, peripherals, VME); slave is the arbiter
  modport master (
    output cpu_as, cpu_fc, address_16, cpu_ack_level, irq, dev_dtack, vme_ipl,
    input  cpu_ipl, cpu_avec, iack, vme_iack
  );

  modport slave (
    input  cpu_as, cpu_fc, address_16, cpu_ack_level, irq, dev_dtack, vme_ipl,
    output cpu_ipl, cpu_avec, iack, vme_iack
  );
endinterface

// File: rtl/interrupt_arbiter.sv
// k30p interrupt controller: merges local irqs and VME IPL into cpu_ipl and routes 68030 IACK cycles.
// Optional macro INTERRUPT_AUTOVEC_FALLBACK_EN: acknowledge timeout falls back to autovector.
module interrupt_arbiter #(
  parameter int unsigned                NUM_SOURCES    = 4,
  // source i level lives in bits [3i+2:3i]: source 0 = level 2 ... source 3 = level 5
  parameter logic [3*NUM_SOURCES-1:0]   SOURCE_LEVELS  = {3'd5, 3'd4, 3'd3, 3'd2},
  parameter int unsigned                TIMEOUT_CYCLES = 64
) (
  input logic                clock,
  input logic                reset,
  interrupt_arbiter_if.slave intr
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned      IDX_W    = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef INTERRUPT_AUTOVEC_FALLBACK_EN
  localparam bit FALLBACK_EN = 1'b1;
`else
  localparam bit FALLBACK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    ACK_LOCAL,
    ACK_VME,
    AVEC,
    WAIT_RELEASE
  } state_e;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_LOCAL,
    GRANT_VME
  } grant_e;

  logic [NUM_SOURCES-1:0] irq_meta_q, irq_sync_q;
  logic                   as_meta_q, as_sync_q;
  logic                   dtack_meta_q, dtack_sync_q;
  logic [2:0]             vme_meta_q, vme_sync_q;

  state_e                 state_q, state_d;
  grant_e                 grant_kind_q, grant_kind_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             ipl_q, ipl_d;
  logic [NUM_SOURCES-1:0] iack_q, iack_d;
  logic                   vme_iack_q, vme_iack_d;
  logic                   avec_q, avec_d;

  logic [2:0]             local_level;
  logic [2:0]             vme_level;
  logic [2:0]             max_level;
  grant_e                 sel_kind;
  logic [IDX_W-1:0]       sel_idx;
  logic                   iack_detect;

  // All asynchronous inputs are active-low, so the idle/reset value is all ones
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_meta_q   <= '1;
      irq_sync_q   <= '1;
      as_meta_q    <= 1'b1;
      as_sync_q    <= 1'b1;
      dtack_meta_q <= 1'b1;
      dtack_sync_q <= 1'b1;
      vme_meta_q   <= '1;
      vme_sync_q   <= '1;
    end else begin
      irq_meta_q   <= intr.irq;
      irq_sync_q   <= irq_meta_q;
      as_meta_q    <= intr.cpu_as;
      as_sync_q    <= as_meta_q;
      dtack_meta_q <= intr.dev_dtack;
      dtack_sync_q <= dtack_meta_q;
      vme_meta_q   <= intr.vme_ipl;
      vme_sync_q   <= vme_meta_q;
    end
  end

  always_comb begin
    local_level = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if (!irq_sync_q[i] && (SOURCE_LEVELS[3*i +: 3] > local_level)) begin
        local_level = SOURCE_LEVELS[3*i +: 3];
      end
    end
  end

  assign vme_level   = ~vme_sync_q;
  assign max_level   = (local_level > vme_level) ? local_level : vme_level;
  assign iack_detect = !as_sync_q && (intr.cpu_fc == 3'b111) && intr.address_16;

  // Lowest index wins among local sources; VME only if no local source matches
  always_comb begin
    sel_kind = GRANT_NONE;
    sel_idx  = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if ((sel_kind != GRANT_LOCAL) && !irq_sync_q[i] &&
          (SOURCE_LEVELS[3*i +: 3] != 3'd0) &&
          (SOURCE_LEVELS[3*i +: 3] == intr.cpu_ack_level)) begin
        sel_kind = GRANT_LOCAL;
        sel_idx  = IDX_W'(i);
      end
    end
    if ((sel_kind == GRANT_NONE) && (vme_level != 3'd0) &&
        (vme_level == intr.cpu_ack_level)) begin
      sel_kind = GRANT_VME;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_kind_q <= GRANT_NONE;
      grant_idx_q  <= '0;
      cnt_q        <= '0;
      ipl_q        <= 3'b111;
      iack_q       <= '1;
      vme_iack_q   <= 1'b1;
      avec_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_kind_q <= grant_kind_d;
      grant_idx_q  <= grant_idx_d;
      cnt_q        <= cnt_d;
      ipl_q        <= ipl_d;
      iack_q       <= iack_d;
      vme_iack_q   <= vme_iack_d;
      avec_q       <= avec_d;
    end
  end

  // Acknowledge outputs are registered and hold by default, so WAIT_RELEASE keeps
  // whichever one was asserted without re-deriving it from the grantee.
  always_comb begin
    state_d      = state_q;
    grant_kind_d = grant_kind_q;
    grant_idx_d  = grant_idx_q;
    cnt_d        = cnt_q;
    ipl_d        = ipl_q;
    iack_d       = iack_q;
    vme_iack_d   = vme_iack_q;
    avec_d       = avec_q;

    if ((state_q != IDLE) && as_sync_q) begin
      state_d    = IDLE;
      cnt_d      = '0;
      iack_d     = '1;
      vme_iack_d = 1'b1;
      avec_d     = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          ipl_d = ~max_level;
          if (iack_detect) begin
            state_d      = DECODE;
            grant_kind_d = sel_kind;
            grant_idx_d  = sel_idx;
          end
        end

        DECODE: begin
          cnt_d = '0;
          unique case (grant_kind_q)
            GRANT_LOCAL: begin
              state_d = ACK_LOCAL;
              iack_d  = ~(NUM_SOURCES'(1) << grant_idx_q);
            end
            GRANT_VME: begin
              state_d    = ACK_VME;
              vme_iack_d = 1'b0;
            end
            default: begin
              state_d = AVEC;
              avec_d  = 1'b0;
            end
          endcase
        end

        ACK_LOCAL, ACK_VME: begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (!dtack_sync_q) begin
            state_d = WAIT_RELEASE;
          end else if (FALLBACK_EN && (cnt_q == CNT_LAST)) begin
            state_d    = AVEC;
            iack_d     = '1;
            vme_iack_d = 1'b1;
            avec_d     = 1'b0;
          end
        end

        AVEC: begin
          state_d = WAIT_RELEASE;
        end

        WAIT_RELEASE: begin
          state_d = WAIT_RELEASE;
        end

        default: begin
          state_d    = IDLE;
          cnt_d      = '0;
          iack_d     = '1;
          vme_iack_d = 1'b1;
          avec_d     = 1'b1;
        end
      endcase
    end
  end

  assign intr.cpu_ipl  = ipl_q;
  assign intr.iack     = iack_q;
  assign intr.vme_iack = vme_iack_q;
  assign intr.cpu_avec = avec_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed self-checking bench for interrupt_arbiter; expectations depend on
// whether INTERRUPT_AUTOVEC_FALLBACK_EN is defined for the build.
module tb_interrupt_arbiter;

  logic clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  interrupt_arbiter_if #(.NUM_SOURCES(4)) intr ();

  interrupt_arbiter #(
    .NUM_SOURCES   (4),
    .SOURCE_LEVELS ({3'd5, 3'd4, 3'd3, 3'd2}),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clock(clock),
    .reset(reset),
    .intr (intr)
  );

  always #5 clock = ~clock;

`ifdef INTERRUPT_AUTOVEC_FALLBACK_EN
  localparam bit FB = 1'b1;
`else
  localparam bit FB = 1'b0;
`endif

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ipl(input string tag, input logic [2:0] exp);
    chk({tag, ".ipl"}, 8'(intr.cpu_ipl), 8'(exp));
  endtask

  task automatic chk_acks(input string tag, input logic [3:0] ia, input logic v, input logic a);
    int unsigned zeros;
    chk({tag, ".iack"}, 8'(intr.iack), 8'(ia));
    chk({tag, ".vme_iack"}, 8'(intr.vme_iack), 8'(v));
    chk({tag, ".avec"}, 8'(intr.cpu_avec), 8'(a));
    zeros = $countones(~intr.iack) + (intr.vme_iack === 1'b0 ? 1 : 0)
            + (intr.cpu_avec === 1'b0 ? 1 : 0);
    chk({tag, ".excl"}, 8'(zeros <= 1), 8'd1);
  endtask

  task automatic start_iack(input logic [2:0] lvl);
    intr.cpu_fc        = 3'b111;
    intr.address_16    = 1'b1;
    intr.cpu_ack_level = lvl;
    intr.cpu_as        = 1'b0;
  endtask

  task automatic end_iack();
    intr.cpu_as     = 1'b1;
    intr.cpu_fc     = 3'b000;
    intr.address_16 = 1'b0;
    intr.dev_dtack  = 1'b1;
  endtask

  initial begin
    reset              = 1'b1;
    intr.cpu_as        = 1'b1;
    intr.cpu_fc        = 3'b000;
    intr.address_16    = 1'b0;
    intr.cpu_ack_level = 3'd0;
    intr.irq           = 4'b0000;
    intr.dev_dtack     = 1'b1;
    intr.vme_ipl       = 3'b111;

    // reset held two clocks with every irq active
    tick(1);
    chk_ipl("rst1", 3'b111);
    chk_acks("rst1", 4'b1111, 1'b1, 1'b1);
    tick(1);
    chk_ipl("rst2", 3'b111);
    chk_acks("rst2", 4'b1111, 1'b1, 1'b1);
    reset = 1'b0;
    tick(1);
    chk_ipl("post_rst1", 3'b111);
    tick(1);
    chk_ipl("post_rst2", 3'b111);
    tick(1);
    chk_ipl("post_rst3", 3'b010);
    chk_acks("post_rst3", 4'b1111, 1'b1, 1'b1);

    // priority: local level 2 vs VME level 3, then local level 5
    intr.irq     = 4'b1110;
    intr.vme_ipl = 3'b100;
    tick(3);
    chk_ipl("prio_vme3", 3'b100);
    intr.irq = 4'b0110;
    tick(3);
    chk_ipl("prio_loc5", 3'b010);

    // local acknowledge of source 3 at level 5
    intr.irq     = 4'b0111;
    intr.vme_ipl = 3'b111;
    tick(3);
    chk_ipl("lack_pre", 3'b010);
    start_iack(3'd5);
    tick(3);
    chk_acks("lack_decode", 4'b1111, 1'b1, 1'b1);
    tick(1);
    chk_acks("lack_on", 4'b0111, 1'b1, 1'b1);
    intr.dev_dtack = 1'b0;
    tick(3);
    chk_acks("lack_dtack", 4'b0111, 1'b1, 1'b1);
    intr.irq = 4'b1111;
    tick(3);
    chk_ipl("lack_hold", 3'b010);
    chk_acks("lack_hold", 4'b0111, 1'b1, 1'b1);
    end_iack();
    tick(2);
    chk_acks("lack_rel2", 4'b0111, 1'b1, 1'b1);
    tick(1);
    chk_acks("lack_rel3", 4'b1111, 1'b1, 1'b1);
    tick(1);
    chk_ipl("lack_idle_ipl", 3'b111);

    // tie at level 2: local source 0 beats VME; cycle aborted without dtack
    intr.vme_ipl = 3'b101;
    intr.irq     = 4'b1110;
    tick(3);
    chk_ipl("tie_pre", 3'b101);
    start_iack(3'd2);
    tick(4);
    chk_acks("tie_local", 4'b1110, 1'b1, 1'b1);
    end_iack();
    tick(3);
    chk_acks("tie_abort", 4'b1111, 1'b1, 1'b1);

    // local source dropped: VME takes level 2
    intr.irq = 4'b1111;
    tick(3);
    chk_ipl("vme_pre", 3'b101);
    start_iack(3'd2);
    tick(4);
    chk_acks("vme_on", 4'b1111, 1'b0, 1'b1);
    intr.dev_dtack = 1'b0;
    tick(3);
    chk_acks("vme_dtack", 4'b1111, 1'b0, 1'b1);
    end_iack();
    tick(3);
    chk_acks("vme_rel", 4'b1111, 1'b1, 1'b1);

    // spurious acknowledge at level 6
    intr.irq     = 4'b0111;
    intr.vme_ipl = 3'b111;
    tick(3);
    chk_ipl("spur_pre", 3'b010);
    start_iack(3'd6);
    tick(4);
    chk_acks("spur_avec", 4'b1111, 1'b1, 1'b0);
    tick(5);
    chk_acks("spur_hold", 4'b1111, 1'b1, 1'b0);
    end_iack();
    tick(3);
    chk_acks("spur_rel", 4'b1111, 1'b1, 1'b1);

    // timeout: no dtack, grantee drops its request mid-acknowledge
    start_iack(3'd5);
    tick(4);
    chk_acks("to_on", 4'b0111, 1'b1, 1'b1);
    intr.irq = 4'b1111;
    tick(63);
    chk_acks("to_63", 4'b0111, 1'b1, 1'b1);
    chk_ipl("to_63", 3'b010);
    tick(1);
    chk_acks("to_64", FB ? 4'b1111 : 4'b0111, 1'b1, FB ? 1'b0 : 1'b1);
    tick(10);
    chk_acks("to_74", FB ? 4'b1111 : 4'b0111, 1'b1, FB ? 1'b0 : 1'b1);
    end_iack();
    tick(3);
    chk_acks("to_rel", 4'b1111, 1'b1, 1'b1);

    // second timeout run: the counter must restart from zero
    intr.irq = 4'b0111;
    tick(3);
    start_iack(3'd5);
    tick(4);
    chk_acks("to2_on", 4'b0111, 1'b1, 1'b1);
    tick(63);
    chk_acks("to2_63", 4'b0111, 1'b1, 1'b1);
    tick(1);
    chk_acks("to2_64", FB ? 4'b1111 : 4'b0111, 1'b1, FB ? 1'b0 : 1'b1);

    // reset in the middle of an acknowledge
    reset = 1'b1;
    end_iack();
    tick(1);
    chk_ipl("midrst", 3'b111);
    chk_acks("midrst", 4'b1111, 1'b1, 1'b1);
    reset = 1'b0;
    tick(3);
    chk_ipl("midrst_after", 3'b010);
    chk_acks("midrst_after", 4'b1111, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
